// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM driving datapath strobes, with
// parameterised memory wait states and a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCWriteCondNot,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             ImmSrc,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       RegDst,
  output logic [2:0]       MemToReg,
  output logic [3:0]       ALUOp,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StTrap   = 4'd15
  } state_e;

  localparam logic [5:0] OpR     = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] FnJr    = 6'b001000;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluRtyp = 4'b0010;
  localparam logic [3:0] AluAnd  = 4'b0011;
  localparam logic [3:0] AluOr   = 4'b0100;
  localparam logic [3:0] AluXor  = 4'b0101;
  localparam logic [3:0] AluSlt  = 4'b0110;
  localparam logic [3:0] AluLui  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;

  localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wait_last;
  logic             retire;

  assign wait_last = (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (wait_last) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw:   state_d = StMemAdr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ, OpJal:   state_d = StJump;
          OpR:          state_d = (funct == FnJr) ? StJump : StExec;
          OpAddi, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: state_d = StExec;
          default:      state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (wait_last) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (wait_last) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAluWb, StBranch, StJump: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  // Only instruction-completing states ever move to FETCH, so this is the retire condition.
  assign retire  = (state_d == StFetch) && (state_q != StFetch);
  // Any state change restarts the wait counter; only FETCH/MEMRD/MEMWR actually use it.
  assign wait_d  = (state_d != state_q) ? 4'd0 : wait_q + 4'd1;
  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      wait_q  <= 4'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    PCWriteCondNot = 1'b0;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    IRWrite        = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = 1'b0;
    ImmSrc         = 1'b0;
    ALUSrcB        = 2'b00;
    PCSource       = 2'b00;
    RegDst         = 2'b00;
    MemToReg       = 3'b000;
    ALUOp          = AluAdd;
    halted         = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // Gated by rst_n so a held reset never latches an instruction.
        IRWrite = wait_last & rst_n;
        PCWrite = wait_last & rst_n;
      end
      StDecode: ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      StMemWb: begin
        MemToReg = 3'b001;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        if (opcode == OpR) begin
          ALUSrcB = 2'b00;
          ALUOp   = AluRtyp;
        end else begin
          ALUSrcB = 2'b10;
          case (opcode)
            OpSlti:  ALUOp = AluSlt;
            OpSltiu: ALUOp = AluSltu;
            OpAndi:  ALUOp = AluAnd;
            OpOri:   ALUOp = AluOr;
            OpXori:  ALUOp = AluXor;
            OpLui:   ALUOp = AluLui;
            default: ALUOp = AluAdd;
          endcase
          ImmSrc = (opcode == OpAndi) || (opcode == OpOri) || (opcode == OpXori);
        end
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = (opcode == OpR) ? 2'b01 : 2'b00;
      end
      StBranch: begin
        ALUSrcA        = 1'b1;
        ALUOp          = AluSub;
        PCSource       = 2'b01;
        PCWriteCond    = (opcode == OpBeq);
        PCWriteCondNot = (opcode == OpBne);
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = (opcode == OpR) ? 2'b11 : 2'b10;
        if (opcode == OpJal) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemToReg = 3'b010;
        end
      end
      StTrap:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT, default 0: extra wait cycles per memory access (0..15); each memory state lasts MEM_WAIT+1 cycles.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-005 opcode  input  6  IR[31:26]; funct  input  6  IR[5:0]; both stable from the DECODE state onward.
REQ-006 PCWrite, PCWriteCond, PCWriteCondNot, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ImmSrc  output  1 each  datapath strobes and mux selects.
REQ-007 ALUSrcB  output  2 (00 reg B, 01 const 4, 10 imm, 11 imm<<2); PCSource  output  2 (00 ALU, 01 ALUOut, 10 jump target, 11 rs).
REQ-008 RegDst  output  2 (00 rt, 01 rd, 10 $31); MemToReg  output  3 (000 ALUOut, 001 MDR, 010 PC).
REQ-009 ALUOp  output  4: ADD 0000, SUB 0001, R-type 0010, AND 0011, OR 0100, XOR 0101, SLT 0110, LUI 0111, SLTU 1000.
REQ-010 state  output  4  current state code; halted  output  1  TRAP state; instr_count  output  CNT_W  retired instructions.

Function
REQ-011 Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, SLTI 001010, SLTIU 001011, ANDI 001100, ORI 001101, XORI 001110, LUI 001111, J 000010, JAL 000011; JR is R-type with funct 001000.
REQ-012 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, TRAP 15; outputs are a Moore function of state (plus opcode/funct from EXEC on).
REQ-013 Outputs not listed for a state are 0; ALUOp defaults to ADD.
REQ-014 A 4-bit wait counter clears on entry to FETCH, MEMRD, MEMWR and advances each cycle; the state exits when the counter equals MEM_WAIT.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00; IRWrite=1 and PCWrite=1 on the final FETCH cycle only; then DECODE.
REQ-016 DECODE (1 cycle): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD; next: LW/SW->MEMADR, BEQ/BNE->BRANCH, J/JAL/JR->JUMP, other R-type and immediate ops->EXEC, any other opcode->TRAP.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, ImmSrc=0; LW->MEMRD, SW->MEMWR.
REQ-018 MEMRD: IorD=1, MemRead=1 every cycle; then MEMWB. MEMWB: RegDst=00, MemToReg=001, RegWrite=1; then FETCH.
REQ-019 MEMWR: IorD=1, MemWrite=1 every cycle; then FETCH.
REQ-020 EXEC: ALUSrcA=1; R-type ALUSrcB=00, ALUOp=0010; immediates ALUSrcB=10, ALUOp per REQ-009; ImmSrc=1 for ANDI/ORI/XORI, 0 otherwise; then ALUWB.
REQ-021 ALUWB: RegWrite=1, MemToReg=000, RegDst=01 for R-type, 00 otherwise; then FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, PCWriteCond=1 (BEQ) or PCWriteCondNot=1 (BNE); then FETCH.
REQ-023 JUMP: PCWrite=1; J/JAL PCSource=10; JR PCSource=11; JAL also RegWrite=1, RegDst=10, MemToReg=010 (samples PC already holding PC+4); then FETCH.
REQ-024 TRAP: all strobes 0, halted=1; remains until reset.
REQ-025 instr_count increments by 1 in each cycle that transitions to FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP; wraps from all-ones to 0; TRAP entry does not count.

Reset
REQ-026 When rst_n=0 at a rising edge: state=FETCH, wait counter=0, instr_count=0, halted=0, regardless of current state (including mid-wait or TRAP).
REQ-027 Reset held low: outputs show FETCH decode with IRWrite/PCWrite gated to 0; first fetch completes MEM_WAIT+1 cycles after release.

Verification
REQ-028 MEM_WAIT=0, ADDI: states 0,1,6,7,0; RegWrite=1, RegDst=00, ALUOp=0000 in ALUWB; instr_count=1 after 4 cycles.
REQ-029 MEM_WAIT=2, LW: FETCH 3 cycles with IRWrite only in 3rd, MEMRD 3 cycles MemRead=1 IorD=1, MEMWB MemToReg=001; total 9 cycles, count=1.
REQ-030 JAL then JR (funct 001000): JAL JUMP has PCSource=10, RegDst=10, MemToReg=010, RegWrite=1; JR JUMP has PCSource=11, RegWrite=0.
REQ-031 Opcode 111111: DECODE->TRAP, halted=1 for 20 cycles, count unchanged; rst_n=0 one edge -> state=0, halted=0, count=0.
REQ-032 CNT_W=4, 17 BEQ instructions: PCWriteCond=1, ALUOp=0001 in BRANCH; count wraps 15->0, reads 1 at end.
REQ-033 MEM_WAIT=3, reset asserted during 2nd MEMWR cycle: next state FETCH, MemWrite=0, wait counter restarts.
